// File: rtl/mvm_ctrl_pkg.sv
// Shared types for the queued MVM controller: FSM state, host command layout
// and the accumulator marker tuple carried through the read-latency pipeline.
package mvm_ctrl_pkg;

   localparam int DEF_VEC_ADDRW = 8;
   localparam int DEF_MAT_ADDRW = 9;
   localparam int DEF_VEC_SIZEW = DEF_VEC_ADDRW + 1;
   localparam int DEF_MAT_SIZEW = DEF_MAT_ADDRW + 1;
   localparam int DEF_RD_LAT    = 2;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      COMPUTE = 1'b1
   } state_t;

   typedef struct packed {
      logic [DEF_VEC_ADDRW-1:0] vec_base;
      logic [DEF_VEC_SIZEW-1:0] words;
      logic [DEF_MAT_ADDRW-1:0] mat_base;
      logic [DEF_MAT_SIZEW-1:0] rows;
      logic [DEF_MAT_SIZEW-1:0] stride;
   } cmd_t;

   typedef struct packed {
      logic valid;
      logic first;
      logic last;
      logic jobend;
   } marker_t;

   localparam marker_t MARKER_IDLE = '{valid: 1'b0, first: 1'b0, last: 1'b0, jobend: 1'b0};

endpackage

// File: rtl/mvm_ctrl_q_if.sv
// Host command, stall, RAM address and accumulator marker signals of the
// queued MVM controller; the controller uses the slave side.
interface mvm_ctrl_q_if #(
   parameter int VEC_ADDRW = 8,
   parameter int MAT_ADDRW = 9,
   parameter int VEC_SIZEW = VEC_ADDRW + 1,
   parameter int MAT_SIZEW = MAT_ADDRW + 1
);
   logic                 start;
   logic                 cmd_ready;
   logic [VEC_ADDRW-1:0] vec_start_addr;
   logic [VEC_SIZEW-1:0] vec_num_words;
   logic [MAT_ADDRW-1:0] mat_start_addr;
   logic [MAT_SIZEW-1:0] mat_num_rows_per_olane;
   logic [MAT_SIZEW-1:0] mat_row_stride;
   logic                 stall;
   logic [VEC_ADDRW-1:0] vec_raddr;
   logic [MAT_ADDRW-1:0] mat_raddr;
   logic                 accum_first;
   logic                 accum_last;
   logic                 ovalid;
   logic                 done;
   logic                 cmd_err;
   logic                 busy;

   modport master (
      output start, vec_start_addr, vec_num_words, mat_start_addr,
             mat_num_rows_per_olane, mat_row_stride, stall,
      input  cmd_ready, vec_raddr, mat_raddr, accum_first, accum_last,
             ovalid, done, cmd_err, busy
   );

   modport slave (
      input  start, vec_start_addr, vec_num_words, mat_start_addr,
             mat_num_rows_per_olane, mat_row_stride, stall,
      output cmd_ready, vec_raddr, mat_raddr, accum_first, accum_last,
             ovalid, done, cmd_err, busy
   );
endinterface

// File: rtl/mvm_marker_delay.sv
// Delays the accumulator marker tuple by the RAM read latency so it lines up
// with read data; always shifts, never stalls.
module mvm_marker_delay
   import mvm_ctrl_pkg::*;
#(
   parameter int RD_LAT = DEF_RD_LAT
) (
   input  logic    clk,
   input  logic    rst,
   input  marker_t din,
   output marker_t dout,
   output logic    any_valid
);

   marker_t stage_r [RD_LAT];

   // Shift register of marker tuples, cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) begin
            stage_r[i] <= MARKER_IDLE;
         end
      end else begin
         stage_r[0] <= din;
         for (int i = 1; i < RD_LAT; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   // Any beat still in flight keeps the controller busy
   always_comb begin
      any_valid = 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
         any_valid = any_valid | stage_r[i].valid;
      end
   end

   assign dout = stage_r[RD_LAT-1];

endmodule

// File: rtl/mvm_ctrl_q.sv
// MVM read-address controller with a one-deep command queue, row stride,
// issue stall and accumulator markers aligned to the RAM read latency.
module mvm_ctrl_q
   import mvm_ctrl_pkg::*;
#(
   parameter int VEC_ADDRW = DEF_VEC_ADDRW,
   parameter int MAT_ADDRW = DEF_MAT_ADDRW,
   parameter int VEC_SIZEW = VEC_ADDRW + 1,
   parameter int MAT_SIZEW = MAT_ADDRW + 1,
   parameter int RD_LAT    = DEF_RD_LAT
) (
   input logic         clk,
   input logic         rst,
   mvm_ctrl_q_if.slave bus
);

   localparam int SUMW = (VEC_SIZEW > MAT_ADDRW) ? VEC_SIZEW : MAT_ADDRW;

   state_t               state_r;
   logic [VEC_ADDRW-1:0] vec_base_r;
   logic [VEC_SIZEW-1:0] words_r;
   logic [MAT_SIZEW-1:0] rows_r;
   logic [MAT_ADDRW-1:0] row_base_r;
   logic [MAT_SIZEW-1:0] stride_r;
   logic [VEC_SIZEW-1:0] word_cnt_r;
   logic [MAT_SIZEW-1:0] row_cnt_r;
   logic                 pend_valid_r;
   logic [VEC_ADDRW-1:0] pend_vec_base_r;
   logic [VEC_SIZEW-1:0] pend_words_r;
   logic [MAT_ADDRW-1:0] pend_mat_base_r;
   logic [MAT_SIZEW-1:0] pend_rows_r;
   logic [MAT_SIZEW-1:0] pend_stride_r;
   logic                 cmd_err_r;

   logic                 accept_s;
   logic                 zero_s;
   logic                 issue_s;
   logic                 last_word_s;
   logic                 last_row_s;
   logic                 jobend_s;
   logic                 load_s;
   logic                 store_pend_s;
   logic                 go_idle_s;
   logic [VEC_ADDRW-1:0] ld_vec_base_s;
   logic [VEC_SIZEW-1:0] ld_words_s;
   logic [MAT_ADDRW-1:0] ld_mat_base_s;
   logic [MAT_SIZEW-1:0] ld_rows_s;
   logic [MAT_SIZEW-1:0] ld_stride_s;
   marker_t              mark_s;
   marker_t              mark_out_s;
   logic                 any_valid_s;

   // Command acceptance, issue decode and next-job selection
   always_comb begin
      accept_s     = bus.start && !pend_valid_r;
      zero_s       = (bus.vec_num_words == {VEC_SIZEW{1'b0}}) ||
                     (bus.mat_num_rows_per_olane == {MAT_SIZEW{1'b0}});
      issue_s      = (state_r == COMPUTE) && !bus.stall;
      last_word_s  = (word_cnt_r == (words_r - VEC_SIZEW'(1'b1)));
      last_row_s   = (row_cnt_r == (rows_r - MAT_SIZEW'(1'b1)));
      jobend_s     = issue_s && last_word_s && last_row_s;
      load_s       = ((state_r == IDLE) && accept_s && !zero_s) ||
                     (jobend_s && (pend_valid_r || (accept_s && !zero_s)));
      store_pend_s = (state_r == COMPUTE) && accept_s && !zero_s && !jobend_s;
      go_idle_s    = jobend_s && !load_s;
      // The pending slot is only ever occupied while computing
      if (pend_valid_r) begin
         ld_vec_base_s = pend_vec_base_r;
         ld_words_s    = pend_words_r;
         ld_mat_base_s = pend_mat_base_r;
         ld_rows_s     = pend_rows_r;
         ld_stride_s   = pend_stride_r;
      end else begin
         ld_vec_base_s = bus.vec_start_addr;
         ld_words_s    = bus.vec_num_words;
         ld_mat_base_s = bus.mat_start_addr;
         ld_rows_s     = bus.mat_num_rows_per_olane;
         ld_stride_s   = bus.mat_row_stride;
      end
   end

   // Read addresses and the marker tuple for this cycle's issue
   always_comb begin
      mark_s = MARKER_IDLE;
      if (state_r == COMPUTE) begin
         bus.vec_raddr = VEC_ADDRW'(VEC_SIZEW'(vec_base_r) + word_cnt_r);
         bus.mat_raddr = MAT_ADDRW'(SUMW'(row_base_r) + SUMW'(word_cnt_r));
      end else begin
         bus.vec_raddr = {VEC_ADDRW{1'b0}};
         bus.mat_raddr = {MAT_ADDRW{1'b0}};
      end
      if (issue_s) begin
         mark_s.valid  = 1'b1;
         mark_s.first  = (word_cnt_r == {VEC_SIZEW{1'b0}});
         mark_s.last   = last_word_s;
         mark_s.jobend = jobend_s;
      end else begin
         mark_s = MARKER_IDLE;
      end
   end

   // Controller FSM with active counters and the pending command slot
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r         <= IDLE;
         vec_base_r      <= {VEC_ADDRW{1'b0}};
         words_r         <= {VEC_SIZEW{1'b0}};
         rows_r          <= {MAT_SIZEW{1'b0}};
         row_base_r      <= {MAT_ADDRW{1'b0}};
         stride_r        <= {MAT_SIZEW{1'b0}};
         word_cnt_r      <= {VEC_SIZEW{1'b0}};
         row_cnt_r       <= {MAT_SIZEW{1'b0}};
         pend_valid_r    <= 1'b0;
         pend_vec_base_r <= {VEC_ADDRW{1'b0}};
         pend_words_r    <= {VEC_SIZEW{1'b0}};
         pend_mat_base_r <= {MAT_ADDRW{1'b0}};
         pend_rows_r     <= {MAT_SIZEW{1'b0}};
         pend_stride_r   <= {MAT_SIZEW{1'b0}};
         cmd_err_r       <= 1'b0;
      end else begin
         cmd_err_r <= accept_s && zero_s;

         if (load_s) begin
            vec_base_r <= ld_vec_base_s;
            words_r    <= ld_words_s;
            rows_r     <= ld_rows_s;
            row_base_r <= ld_mat_base_s;
            stride_r   <= ld_stride_s;
            word_cnt_r <= {VEC_SIZEW{1'b0}};
            row_cnt_r  <= {MAT_SIZEW{1'b0}};
         end else if (issue_s) begin
            if (last_word_s) begin
               word_cnt_r <= {VEC_SIZEW{1'b0}};
               row_base_r <= MAT_ADDRW'(MAT_SIZEW'(row_base_r) + stride_r);
               row_cnt_r  <= row_cnt_r + MAT_SIZEW'(1'b1);
            end else begin
               word_cnt_r <= word_cnt_r + VEC_SIZEW'(1'b1);
            end
         end

         if (store_pend_s) begin
            pend_valid_r    <= 1'b1;
            pend_vec_base_r <= bus.vec_start_addr;
            pend_words_r    <= bus.vec_num_words;
            pend_mat_base_r <= bus.mat_start_addr;
            pend_rows_r     <= bus.mat_num_rows_per_olane;
            pend_stride_r   <= bus.mat_row_stride;
         end else if (load_s && pend_valid_r) begin
            pend_valid_r <= 1'b0;
         end

         case (state_r)
            IDLE: begin
               if (load_s) begin
                  state_r <= COMPUTE;
               end
            end
            COMPUTE: begin
               if (go_idle_s) begin
                  state_r <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   mvm_marker_delay #(
      .RD_LAT(RD_LAT)
   ) u_delay (
      .clk      (clk),
      .rst      (rst),
      .din      (mark_s),
      .dout     (mark_out_s),
      .any_valid(any_valid_s)
   );

   assign bus.ovalid      = mark_out_s.valid;
   assign bus.accum_first = mark_out_s.first;
   assign bus.accum_last  = mark_out_s.last;
   assign bus.done        = mark_out_s.valid && mark_out_s.jobend;
   assign bus.cmd_ready   = !pend_valid_r;
   assign bus.cmd_err     = cmd_err_r;
   assign bus.busy        = (state_r == COMPUTE) || pend_valid_r || any_valid_s;

endmodule

// File: doc/mvm_ctrl_q.md
Name: mvm_ctrl_q

Overview:
Next-generation MVM control FSM. It issues vector/matrix RAM read addresses for one output lane's dot products and produces accumulator first/last/valid markers aligned to a parametrised RAM read latency. Over the single-shot controller it adds:
- a one-deep command queue, so back-to-back jobs run with no bubble
- a programmable matrix row stride, for padded layouts
- an issue stall input
- a job-done pulse and a zero-size command error pulse

It sits between the host command interface and the vector/matrix RAMs plus the dot-product accumulators.

Parameters:
VEC_ADDRW, 8, vector RAM address width
MAT_ADDRW, 9, matrix RAM address width
VEC_SIZEW, VEC_ADDRW+1, vector word-count width
MAT_SIZEW, MAT_ADDRW+1, row-count and stride width
RD_LAT, 2, RAM read latency in cycles (>=1); marker delay

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start  in  1  command valid
cmd_ready  out  1  command can be accepted this cycle; equals !pending_valid
vec_start_addr  in  VEC_ADDRW  first vector word address
vec_num_words  in  VEC_SIZEW  words per row (dot-product length)
mat_start_addr  in  MAT_ADDRW  address of first matrix row
mat_num_rows_per_olane  in  MAT_SIZEW  rows to process
mat_row_stride  in  MAT_SIZEW  address step between row bases
stall  in  1  hold issue this cycle
vec_raddr  out  VEC_ADDRW  vector read address
mat_raddr  out  MAT_ADDRW  matrix read address
accum_first  out  1  first word of a row, aligned with read data
accum_last  out  1  last word of a row, aligned with read data
ovalid  out  1  read data valid for the accumulator
done  out  1  one-cycle pulse with the final accum_last of a job
cmd_err  out  1  one-cycle pulse the cycle after a zero-size command is accepted
busy  out  1  state==COMPUTE, or pending_valid, or any pipeline stage valid

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1. State IDLE, counters 0, pending slot and pipeline cleared.
- Reset mid-job aborts the job and drops the pending command. Outputs reach reset values the cycle after rst is sampled.
- Command acceptance: a command is accepted when start && cmd_ready.
  - If vec_num_words==0 or mat_num_rows_per_olane==0, the command is dropped and cmd_err pulses the next cycle. State is unaffected.
- States:
  - IDLE: an accepted command loads the active registers (vec base, word count, row count, row base=mat_start_addr, stride); go to COMPUTE.
  - COMPUTE, accepted command while active: it is stored in the pending slot.
- Issue: in COMPUTE with stall=0, one word is issued per cycle.
  - vec_raddr = vec_base + word_cnt; mat_raddr = row_base + word_cnt.
  - Both are combinational from registered counters and are 0 in IDLE.
  - With stall=1, counters and addresses hold and nothing is issued.
- Counter step on each issue:
  - Last word of a row (word_cnt==words-1): word_cnt<=0, row_base<=row_base+stride, row_cnt++.
  - Otherwise word_cnt++.
- Job end (issue of the last word of the last row):
  - If pending_valid: load pending into active, clear pending, stay in COMPUTE. The next issue is the following cycle (no bubble).
  - Else, if a valid command is accepted in this same cycle, load it directly and stay in COMPUTE.
  - Else go to IDLE.
- Arithmetic: all address sums truncate modulo 2^ADDRW (wrap-around is legal). Count compares use the full SIZEW width.
- Marker pipeline: each issue cycle creates a tuple {valid=1, first=(word_cnt==0), last=(word_cnt==words-1), jobend}. A stall or idle cycle creates valid=0.
  - The tuple is delayed exactly RD_LAT cycles. The pipeline always shifts and is never frozen by stall.
  - ovalid/accum_first/accum_last/done come from the final stage, with done = valid && jobend.
  - first and last are both 1 when words==1.
- The first issue occurs the cycle after acceptance. First ovalid occurs RD_LAT cycles after the first issue.

Decomposition:
- Package mvm_ctrl_pkg holds:
  - a state enum {IDLE, COMPUTE}
  - a packed cmd_t struct (vec_base, words, mat_base, rows, stride), parametrised via the package's default widths
  - marker_t {valid, first, last, jobend}
- One sub-module, mvm_marker_delay: an RD_LAT-stage shift register of marker_t with synchronous reset. It also exposes an any_valid OR for busy.

Test Plan:
- Basic job, RD_LAT=2: vec_start=4, words=3, mat_start=16, rows=2, stride=3, start at cycle 0 -> issue cycles 1-6 with vec 4,5,6,4,5,6 and mat 16-21; ovalid cycles 3-8; first at cycles 3,6; last at 5,8; done at 8; busy falls at cycle 9.
- Padded stride: same job with stride=4 -> mat 16,17,18,20,21,22; vec sequence unchanged.
- Stall: stall=1 during cycles 2-3 of the basic job -> addresses hold at vec 5/mat 17 for cycles 2-4; ovalid low at cycles 4-5; total of 6 valid beats; done at cycle 10.
- Back-to-back: second command issued while the first computes; cmd_ready=0 afterwards; a third start is ignored -> the second job's first issue immediately follows the first job's last; ovalid continuous; two done pulses.
- Zero-size and wrap: words=0 -> cmd_err pulse, no issue, busy stays 0. mat_start=510, words=4, rows=1 (MAT_ADDRW=9) -> mat 510,511,0,1.
- Reset mid-job: rst asserted at cycle 4 with a pending command -> the next cycle all outputs are 0 and cmd_ready=1; no done pulse; a fresh start works normally.
